// File: rtl/ptp_tod_reg_pkg.sv
// Shared constants and types for the PTP time-of-day register-write responder.
package ptp_tod_reg_pkg;

    localparam logic [3:0] TOD_FNS_OFF   = 4'h0;
    localparam logic [3:0] TOD_NS_OFF    = 4'h4;
    localparam logic [3:0] TOD_SEC_L_OFF = 4'h8;
    localparam logic [3:0] TOD_SEC_H_OFF = 4'hC;

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    localparam int TOD_REG_BYTES = 4;

    // Layout of the 96-bit ToD word: {sec[47:0], ns[31:0], fns[15:0]}
    localparam int TOD_SEC_MSB = 95;
    localparam int TOD_SEC_LSB = 48;
    localparam int TOD_NS_MSB  = 47;
    localparam int TOD_NS_LSB  = 16;
    localparam int TOD_FNS_MSB = 15;
    localparam int TOD_FNS_LSB = 0;

    typedef enum logic [1:0] {
        TOD_ST_IDLE   = 2'd0,
        TOD_ST_COMMIT = 2'd1,
        TOD_ST_ACK    = 2'd2
    } tod_state_e;

endpackage

// File: rtl/reg_strb_merge.sv
// Combinational byte-strobe merge of a write word into a 32-bit register value.
module reg_strb_merge
    import ptp_tod_reg_pkg::*;
(
    input  logic [31:0]              cur_val,
    input  logic [31:0]              wr_data,
    input  logic [TOD_REG_BYTES-1:0] wr_strb,
    output logic [31:0]              merged
);

    always_comb begin
        merged = cur_val;
        for (int b = 0; b < TOD_REG_BYTES; b++) begin
            if (wr_strb[b]) begin
                merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ptp_tod_reg_wr_responder.sv
// PTP ToD register-write responder: shadows fns/ns/sec and commits the 96-bit ToD.
// Optional commit-ack timeout enabled by defining PTP_TOD_WR_TIMEOUT_EN.
module ptp_tod_reg_wr_responder
    import ptp_tod_reg_pkg::*;
#(
    parameter int                      REG_ADDR_WIDTH = 16,
    parameter int                      REG_DATA_WIDTH = 32,
    parameter int                      REG_STRB_WIDTH = REG_DATA_WIDTH / 8,
    parameter logic [REG_ADDR_WIDTH-1:0] RB_BASE_ADDR = 16'h0200,
    parameter int                      ACK_TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [REG_DATA_WIDTH-1:0] reg_wr_data,
    input  logic [REG_STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                      reg_wr_en,
    output logic                      reg_wr_wait,
    output logic                      reg_wr_ack,
    output logic                      ts_tod_wr_en,
    output logic [95:0]               ts_tod_wr_ts,
    input  logic                      ts_tod_wr_ack,
    output logic [15:0]               commit_count,
    output logic                      status_err
);

    tod_state_e  state;

    logic [15:0] fns_sh;
    logic [31:0] ns_sh;
    logic [31:0] sec_l_sh;
    logic [15:0] sec_h_sh;

    logic [31:0] fns_mrg;
    logic [31:0] ns_mrg;
    logic [31:0] sec_l_mrg;
    logic [31:0] sec_h_mrg;

    logic        hit;
    logic        accept;
    logic        is_trig;
    logic        ns_in_range;
    logic        tmo_hit;
    logic        unused_hi;

    assign hit         = (reg_wr_addr[REG_ADDR_WIDTH-1:4] == RB_BASE_ADDR[REG_ADDR_WIDTH-1:4]);
    // A request still held on the cycle its ack is visible is the same request, not a new one
    assign accept      = reg_wr_en && hit && (state == TOD_ST_IDLE) && !reg_wr_ack;
    assign is_trig     = (reg_wr_addr[3:0] == TOD_SEC_H_OFF);
    assign ns_in_range = (ns_sh < NS_PER_SEC);
    assign unused_hi   = ^{fns_mrg[31:16], sec_h_mrg[31:16]};

    reg_strb_merge u_fns_merge (
        .cur_val ({16'h0000, fns_sh}),
        .wr_data (reg_wr_data),
        .wr_strb (reg_wr_strb),
        .merged  (fns_mrg)
    );

    reg_strb_merge u_ns_merge (
        .cur_val (ns_sh),
        .wr_data (reg_wr_data),
        .wr_strb (reg_wr_strb),
        .merged  (ns_mrg)
    );

    reg_strb_merge u_sec_l_merge (
        .cur_val (sec_l_sh),
        .wr_data (reg_wr_data),
        .wr_strb (reg_wr_strb),
        .merged  (sec_l_mrg)
    );

    reg_strb_merge u_sec_h_merge (
        .cur_val ({16'h0000, sec_h_sh}),
        .wr_data (reg_wr_data),
        .wr_strb (reg_wr_strb),
        .merged  (sec_h_mrg)
    );

`ifdef PTP_TOD_WR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    // Counts completed COMMIT cycles; restarts on every entry into COMMIT
    always_ff @(posedge clk) begin
        if (rst || state != TOD_ST_COMMIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == TOD_ST_COMMIT) && !ts_tod_wr_ack && (tmo_cnt == TMO_LAST);
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;

    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= TOD_ST_IDLE;
            reg_wr_ack   <= 1'b0;
            reg_wr_wait  <= 1'b0;
            ts_tod_wr_en <= 1'b0;
            ts_tod_wr_ts <= '0;
            commit_count <= '0;
            status_err   <= 1'b0;
            fns_sh       <= '0;
            ns_sh        <= '0;
            sec_l_sh     <= '0;
            sec_h_sh     <= '0;
        end else begin
            reg_wr_ack <= 1'b0;
            case (state)
                TOD_ST_IDLE: begin
                    if (accept) begin
                        case (reg_wr_addr[3:0])
                            TOD_FNS_OFF:   fns_sh   <= fns_mrg[15:0];
                            TOD_NS_OFF:    ns_sh    <= ns_mrg;
                            TOD_SEC_L_OFF: sec_l_sh <= sec_l_mrg;
                            TOD_SEC_H_OFF: sec_h_sh <= sec_h_mrg[15:0];
                            default: ;
                        endcase
                        if (is_trig && ns_in_range) begin
                            ts_tod_wr_ts[TOD_SEC_MSB:TOD_SEC_LSB] <= {sec_h_mrg[15:0], sec_l_sh};
                            ts_tod_wr_ts[TOD_NS_MSB:TOD_NS_LSB]   <= ns_sh;
                            ts_tod_wr_ts[TOD_FNS_MSB:TOD_FNS_LSB] <= fns_sh;
                            ts_tod_wr_en <= 1'b1;
                            reg_wr_wait  <= 1'b1;
                            state        <= TOD_ST_COMMIT;
                        end else begin
                            // Out-of-range ns rejects the commit but still completes the write
                            reg_wr_ack <= 1'b1;
                            if (is_trig) begin
                                status_err <= 1'b1;
                            end
                        end
                    end
                end
                TOD_ST_COMMIT: begin
                    if (ts_tod_wr_ack) begin
                        ts_tod_wr_en <= 1'b0;
                        commit_count <= commit_count + 16'd1;
                        state        <= TOD_ST_ACK;
                    end else if (tmo_hit) begin
                        ts_tod_wr_en <= 1'b0;
                        status_err   <= 1'b1;
                        state        <= TOD_ST_ACK;
                    end
                end
                TOD_ST_ACK: begin
                    reg_wr_ack  <= 1'b1;
                    reg_wr_wait <= 1'b0;
                    state       <= TOD_ST_IDLE;
                end
                default: begin
                    state <= TOD_ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptp_tod_reg_wr_responder.sv
// Randomized self-checking bench for ptp_tod_reg_wr_responder against a register-level model.
module tb_ptp_tod_reg_wr_responder;

    localparam logic [15:0] BASE = 16'h0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic [3:0]  reg_wr_strb = '0;
    logic        reg_wr_en = 1'b0;
    logic        reg_wr_wait;
    logic        reg_wr_ack;
    logic        ts_tod_wr_en;
    logic [95:0] ts_tod_wr_ts;
    logic        ts_tod_wr_ack = 1'b0;
    logic [15:0] commit_count;
    logic        status_err;

    ptp_tod_reg_wr_responder dut (
        .clk           (clk),
        .rst           (rst),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_wait   (reg_wr_wait),
        .reg_wr_ack    (reg_wr_ack),
        .ts_tod_wr_en  (ts_tod_wr_en),
        .ts_tod_wr_ts  (ts_tod_wr_ts),
        .ts_tod_wr_ack (ts_tod_wr_ack),
        .commit_count  (commit_count),
        .status_err    (status_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the four registers as words, plus counters
    logic [31:0] m_sh [4];
    logic [15:0] m_cnt;
    logic        m_err;
    logic [95:0] exp_ts = '0;
    logic [95:0] last_ts = '0;
    int          core_n = 3;
    logic        spur_ack = 1'b0;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [95:0] m_tod();
        return {m_sh[3][15:0], m_sh[2], m_sh[1], m_sh[0][15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    // Clock-core emulation: acks core_n cycles after en rises (0 = never), checks ts stability
    int en_age = 0;
    initial begin
        forever begin
            @(posedge clk); #2;
            ts_tod_wr_ack = spur_ack;
            if (ts_tod_wr_en) begin
                en_age++;
                if (en_age == 1) begin
                    last_ts = ts_tod_wr_ts;
                    chk("tod_ts", ts_tod_wr_ts, exp_ts);
                end else begin
                    chk("tod_ts_stable", ts_tod_wr_ts, last_ts);
                end
                if (core_n != 0 && en_age == core_n) ts_tod_wr_ack = 1'b1;
            end else begin
                en_age = 0;
            end
        end
    end

    task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit hold_extra);
        int   lat, wcnt, exp_lat, exp_w;
        bit   hit, commit, got;
        logic [3:0] off;
        hit = (addr[15:4] == BASE[15:4]);
        off = addr[3:0];
        commit = 1'b0; exp_lat = 1; exp_w = 0;
        if (hit) begin
            m_sh[off[3:2]] = bmerge(m_sh[off[3:2]], data, strb);
            if (off == 4'hC) begin
                if (m_sh[1] < 32'd1_000_000_000) begin
                    commit = 1'b1;
                    exp_ts = m_tod();
                    exp_lat = core_n + 2;
                    exp_w = core_n + 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        reg_wr_addr = addr; reg_wr_data = data; reg_wr_strb = strb; reg_wr_en = 1'b1;
        lat = 0; wcnt = 0; got = 1'b0;
        if (!hit) begin
            repeat (4) begin
                @(posedge clk); #1;
                if (reg_wr_ack) lat++;
                if (reg_wr_wait) wcnt++;
            end
            chk("nohit_ack", lat, 0);
            chk("nohit_wait", wcnt, 0);
        end else begin
            for (int c = 1; c <= 2000 && !got; c++) begin
                @(posedge clk); #1;
                if (reg_wr_ack) begin
                    got = 1'b1;
                    lat = c;
                end else if (reg_wr_wait) begin
                    wcnt++;
                end
            end
            chk("ack_seen", got, 1);
            chk("ack_latency", lat, exp_lat);
            chk("wait_cycles", wcnt, exp_w);
            if (commit) m_cnt++;
            if (hold_extra) begin
                @(posedge clk); #1;
                chk("no_double_ack", reg_wr_ack, 0);
            end
        end
        reg_wr_en = 1'b0;
        chk("commit_count", commit_count, m_cnt);
        chk("status_err", status_err, m_err);
        chk("tod_en_idle", ts_tod_wr_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        bit          got;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", reg_wr_ack, 0);
        chk("rst_wait", reg_wr_wait, 0);
        chk("rst_tod_en", ts_tod_wr_en, 0);
        chk("rst_tod_ts", ts_tod_wr_ts, 0);
        chk("rst_count", commit_count, 0);
        chk("rst_err", status_err, 0);
        rst = 1'b0;

        // Basic ToD set
        core_n = 3;
        bus_wr(BASE + 16'h0, 32'h0000_8000, 4'hF, 1'b0);
        bus_wr(BASE + 16'h4, 32'd500_000_000, 4'hF, 1'b1);
        bus_wr(BASE + 16'h8, 32'h1234_5678, 4'hF, 1'b0);
        bus_wr(BASE + 16'hC, 32'h0000_0001, 4'hF, 1'b1);
        chk("tc1_ts", last_ts, 96'h000112345678_1DCD6500_8000);
        chk("tc1_count", commit_count, 16'd1);

        // Slow clock-core ack: wait held 21 cycles
        core_n = 20;
        bus_wr(BASE + 16'hC, 32'h0000_0001, 4'hF, 1'b1);

        // Partial strobes visible through a commit
        core_n = 2;
        bus_wr(BASE + 16'h4, 32'h1ABB_CCDD, 4'hF, 1'b0);
        bus_wr(BASE + 16'h4, 32'h1122_3344, 4'h5, 1'b0);
        bus_wr(BASE + 16'hC, 32'hFFFF_0002, 4'h3, 1'b0);
        chk("strb_ns", last_ts[47:16], 32'h1A22_CC44);
        chk("strb_sech", last_ts[95:80], 16'h0002);

        // Abandoned request: en dropped mid-COMMIT, a new write during COMMIT is not merged
        core_n = 10;
        m_sh[3] = bmerge(m_sh[3], 32'h0000_0033, 4'hF);
        exp_ts = m_tod();
        @(posedge clk); #1;
        reg_wr_addr = BASE + 16'hC; reg_wr_data = 32'h0000_0033; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reg_wr_en = 1'b0;
        chk("abandon_wait", reg_wr_wait, 1);
        @(posedge clk); #1;
        reg_wr_addr = BASE + 16'h4; reg_wr_data = 32'h0000_0001; reg_wr_en = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk); #1;
            if (reg_wr_ack) got = 1'b1;
        end
        reg_wr_en = 1'b0;
        m_cnt++;
        chk("abandon_ack", got, 1);
        chk("abandon_count", commit_count, m_cnt);
        core_n = 1;
        bus_wr(BASE + 16'hC, 32'h0000_0034, 4'hF, 1'b0);

        // Spurious clock-core ack while idle
        @(posedge clk); #1;
        spur_ack = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("spur_count", commit_count, m_cnt);
        chk("spur_tod_en", ts_tod_wr_en, 0);

        // Reset three cycles into COMMIT
        core_n = 0;
        bus_wr(BASE + 16'h4, 32'd7, 4'hF, 1'b0);
        m_sh[3] = bmerge(m_sh[3], 32'h0000_0007, 4'hF);
        exp_ts = m_tod();
        @(posedge clk); #1;
        reg_wr_addr = BASE + 16'hC; reg_wr_data = 32'h0000_0007; reg_wr_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_tod_en", ts_tod_wr_en, 1);
        rst = 1'b1; reg_wr_en = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_tod_en", ts_tod_wr_en, 0);
        chk("mid_rst_wait", reg_wr_wait, 0);
        chk("mid_rst_count", commit_count, 0);
        rst = 1'b0;
        model_reset();
        core_n = 4;
        bus_wr(BASE + 16'hC, 32'h0000_0055, 4'hF, 1'b0);
        chk("rst_shadow_clr", last_ts, {16'h0055, 80'd0});

        // Out-of-range ns, plus the partial-strobe case from above
        bus_wr(BASE + 16'h4, 32'hAABB_CCDD, 4'hF, 1'b0);
        bus_wr(BASE + 16'h4, 32'h1122_3344, 4'h5, 1'b0);
        bus_wr(BASE + 16'hC, 32'h0000_0001, 4'hF, 1'b0);
        bus_wr(BASE + 16'h10, 32'h0000_0001, 4'hF, 1'b0);
        bus_wr(BASE + 16'h4, 32'h3B9A_CA00, 4'hF, 1'b0);
        bus_wr(BASE + 16'hC, 32'h0000_0001, 4'hF, 1'b1);
        chk("range_err", status_err, 1);

        // Randomized traffic from a clean state
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 150; i++) begin
            core_n = $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) begin
                a = 16'($urandom);
                if (a[15:4] == BASE[15:4]) a[15] = 1'b1;
            end else begin
                a = BASE + 16'({$urandom_range(0, 3), 2'b00});
            end
            if (a[3:0] == 4'h4 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 999_999_999);
            else d = $urandom;
            bus_wr(a, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
